// File: rtl/scan_display_if.sv
// Display bus between the countdown datapath (master) and the scan controller (slave).
interface scan_display_if #(
   parameter int unsigned DIGITS = 4
);
   logic [4*DIGITS-1:0] digits_in;
   logic [DIGITS-1:0]   enable_in;
   logic [DIGITS-1:0]   blink_in;
   logic [DIGITS-1:0]   dp_in;
   logic [6:0]          seg;
   logic                dp_n;
   logic [DIGITS-1:0]   an;

   modport master (
      output digits_in, enable_in, blink_in, dp_in,
      input  seg, dp_n, an
   );

   modport slave (
      input  digits_in, enable_in, blink_in, dp_in,
      output seg, dp_n, an
   );
endinterface

// File: rtl/scan_display_ctrl.sv
// Time-multiplexed common-anode hex display scanner with frame-latched inputs, blink and dp.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module scan_display_ctrl #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   scan_display_if.slave disp
);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned NIB_W = 4 * DIGITS;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

   logic [PRE_W-1:0]  pre_q;
   logic [IDX_W-1:0]  idx_q;
   logic [FRM_W-1:0]  frm_q;
   logic              phase_q;
   logic [NIB_W-1:0]  sh_dig_q;
   logic [DIGITS-1:0] sh_en_q;
   logic [DIGITS-1:0] sh_bl_q;
   logic [DIGITS-1:0] sh_dp_q;
   logic [DIGITS-1:0] lz_c;
   logic [DIGITS-1:0] sh_lz_q;

   logic              tick_c;
   logic              frame_end_c;
   logic [3:0]        nib_c;
   logic              vis_c;
   logic [6:0]        seg_c;
   logic              dp_n_c;
   logic [DIGITS-1:0] an_c;

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'ha: s = 7'b0001000;
         4'hb: s = 7'b1100000;
         4'hc: s = 7'b0110001;
         4'hd: s = 7'b1000010;
         4'he: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign tick_c      = (pre_q == PRE_LAST);
   assign frame_end_c = tick_c && (idx_q == IDX_LAST);

`ifdef LEADING_ZERO_BLANK_EN
   // A zero digit is blanked while every enabled digit above it is also zero.
   always_comb begin
      logic above_zero;
      lz_c       = '0;
      above_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         lz_c[i] = (i != 0) && above_zero && (disp.digits_in[4*i +: 4] == 4'h0);
         if (disp.enable_in[i] && (disp.digits_in[4*i +: 4] != 4'h0)) begin
            above_zero = 1'b0;
         end
      end
   end
`else
   assign lz_c = '0;
`endif

   // Prescaler, digit index, frame/blink counters and frame-end shadow load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q    <= '0;
         idx_q    <= '0;
         frm_q    <= '0;
         phase_q  <= 1'b0;
         sh_dig_q <= '0;
         sh_en_q  <= '0;
         sh_bl_q  <= '0;
         sh_dp_q  <= '0;
         sh_lz_q  <= '0;
      end else begin
         pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
         if (tick_c) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         end
         if (frame_end_c) begin
            sh_dig_q <= disp.digits_in;
            sh_en_q  <= disp.enable_in;
            sh_bl_q  <= disp.blink_in;
            sh_dp_q  <= disp.dp_in;
            sh_lz_q  <= lz_c;
            if (frm_q == FRM_LAST) begin
               frm_q   <= '0;
               phase_q <= ~phase_q;
            end else begin
               frm_q <= frm_q + FRM_W'(1);
            end
         end
      end
   end

   always_comb begin
      nib_c  = sh_dig_q[4*idx_q +: 4];
      an_c   = ~(DIGITS'(1) << idx_q);
      vis_c  = sh_en_q[idx_q] & ~(sh_bl_q[idx_q] & phase_q);
      seg_c  = 7'b1111111;
      dp_n_c = 1'b1;
      if (vis_c) begin
         // Leading-zero digits keep their dp but lose the segments.
         seg_c  = sh_lz_q[idx_q] ? 7'b1111111 : hex_decode(nib_c);
         dp_n_c = ~sh_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp.an   <= '1;
         disp.seg  <= 7'b1111111;
         disp.dp_n <= 1'b1;
      end else begin
         disp.an   <= an_c;
         disp.seg  <= seg_c;
         disp.dp_n <= dp_n_c;
      end
   end
endmodule

// File: tb/tb_scan_display_ctrl.sv
// Randomised bench for scan_display_ctrl against a cycle-count based reference model.
module tb_scan_display_ctrl;
   localparam int unsigned D = 4;
   localparam int unsigned S = 4;
   localparam int unsigned B = 2;
   localparam int unsigned F = D * S;

   localparam logic [6:0] HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic clk = 1'b0;
   logic rst_n;

   scan_display_if #(.DIGITS(D)) disp ();

   scan_display_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLINK_FRAMES(B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .disp  (disp)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: edges since reset release, plus the input snapshot taken at the last frame end.
   int unsigned e;
   logic [15:0] m_dig;
   logic [3:0]  m_en, m_bl, m_dp, m_lz;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dpn;

   function automatic logic [3:0] lz_mask(input logic [15:0] dig, input logic [3:0] en);
      logic [3:0] m;
      m = '0;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 1; i < 4; i++) begin
         logic ok;
         ok = (dig[4*i +: 4] == 4'h0);
         for (int j = i + 1; j < 4; j++)
            if (en[j] && dig[4*j +: 4] != 4'h0) ok = 1'b0;
         m[i] = ok;
      end
`endif
      return m;
   endfunction

   always @(posedge clk) begin
      int  idx;
      bit  ph;
      if (!rst_n) begin
         e = 0;
         m_dig = '0; m_en = '0; m_bl = '0; m_dp = '0; m_lz = '0;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dpn = 1'b1;
      end else begin
         idx    = int'((e / S) % D);
         ph     = ((e / F) / B) % 2 == 1;
         exp_an = ~(4'b0001 << idx);
         if (m_en[idx] && !(m_bl[idx] && ph)) begin
            exp_seg = m_lz[idx] ? 7'h7F : HEX[m_dig[4*idx +: 4]];
            exp_dpn = ~m_dp[idx];
         end else begin
            exp_seg = 7'h7F;
            exp_dpn = 1'b1;
         end
         if (e % F == F - 1) begin
            m_dig = disp.digits_in;
            m_en  = disp.enable_in;
            m_bl  = disp.blink_in;
            m_dp  = disp.dp_in;
            m_lz  = lz_mask(disp.digits_in, disp.enable_in);
         end
         e++;
      end
      #1;
      check("an",   32'(disp.an),   32'(exp_an));
      check("seg",  32'(disp.seg),  32'(exp_seg));
      check("dp_n", 32'(disp.dp_n), 32'(exp_dpn));
   end

   task automatic drive(input logic [15:0] dig, input logic [3:0] en, input logic [3:0] bl,
                        input logic [3:0] dp, input int cycles);
      @(negedge clk);
      disp.digits_in = dig;
      disp.enable_in = en;
      disp.blink_in  = bl;
      disp.dp_in     = dp;
      repeat (cycles - 1) @(negedge clk);
   endtask

   initial begin
      rst_n          = 1'b1;
      disp.digits_in = '0;
      disp.enable_in = '0;
      disp.blink_in  = '0;
      disp.dp_in     = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Mid-frame load of 12AF, then a mid-frame change.
      repeat (5) @(negedge clk);
      drive(16'h12AF, 4'hF, 4'h0, 4'h0, 3 * F);
      repeat (7) @(negedge clk);
      drive(16'h3C5D, 4'hF, 4'h0, 4'h0, 3 * F);
      drive(16'h8888, 4'b0101, 4'h0, 4'b0001, 3 * F);
      drive(16'h4567, 4'hF, 4'b0001, 4'h0, 10 * F);

      // Asynchronous reset between edges.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("rst_an",   32'(disp.an),   32'hF);
      check("rst_seg",  32'(disp.seg),  32'h7F);
      check("rst_dp_n", 32'(disp.dp_n), 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      drive(16'h0070, 4'hF, 4'h0, 4'h0, 3 * F);
      drive(16'h0000, 4'hF, 4'h0, 4'b0100, 3 * F);
      drive(16'h0905, 4'b1011, 4'h0, 4'b0010, 3 * F);

      for (int k = 0; k < 60; k++) begin
         logic [15:0] dig;
         dig = 16'($urandom);
         if ($urandom_range(0, 2) == 0) dig[15:8] = 8'h00;
         drive(dig, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(1, 40)));
      end
      repeat (2 * F) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
